// File: rtl/div_signed_ctrl.sv
// Signed/unsigned request front-end for the unsigned sequential divider.
// Converts operands to magnitudes, drives the divider's level start/done
// handshake, applies the sign fix-up (truncation toward zero, remainder takes
// the dividend's sign) and short-circuits divide-by-zero without the divider.
module div_signed_ctrl #(
    parameter int unsigned N = 64,
    parameter int unsigned M = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_signed,
    input  logic [N-1:0] in_dividend,
    input  logic [M-1:0] in_divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_quotient,
    output logic [M-1:0] out_remainder,
    output logic         out_dz,
    output logic         out_ovf,
    output logic         div_start,
    output logic [N-1:0] div_dividend,
    output logic [M-1:0] div_divisor,
    input  logic         div_done,
    input  logic [N-1:0] div_quotient,
    input  logic [M-1:0] div_remainder
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [N-1:0] MIN_DIVIDEND = {1'b1, {(N-1){1'b0}}};

    state_t       state;
    logic         sq;
    logic         sr;
    logic         ovf_pending;

    logic         dvd_neg;
    logic         dvs_neg;
    logic [N-1:0] dvd_mag;
    logic [M-1:0] dvs_mag;
    logic         divisor_zero;
    logic         ovf_next;
    logic         accept;

    // Operand magnitudes and request classification; negation wraps, so |MIN| = 2^(N-1).
    always_comb begin
        dvd_neg      = in_signed & in_dividend[N-1];
        dvs_neg      = in_signed & in_divisor[M-1];
        dvd_mag      = dvd_neg ? -in_dividend : in_dividend;
        dvs_mag      = dvs_neg ? -in_divisor : in_divisor;
        divisor_zero = (in_divisor == '0);
        ovf_next     = in_signed & (in_dividend == MIN_DIVIDEND) & (&in_divisor);
        accept       = in_valid & in_ready;
    end

    // Control FSM with all outputs registered; in_ready is a flop so it reads 0 while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_dz        <= 1'b0;
            out_ovf       <= 1'b0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            sq            <= 1'b0;
            sr            <= 1'b0;
            ovf_pending   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready     <= 1'b0;
                        sq           <= dvd_neg ^ dvs_neg;
                        sr           <= dvd_neg;
                        div_dividend <= dvd_mag;
                        div_divisor  <= dvs_mag;
                        ovf_pending  <= ovf_next;
                        if (divisor_zero) begin
                            out_quotient  <= '1;
                            out_remainder <= in_dividend[M-1:0];
                            out_dz        <= 1'b1;
                            out_ovf       <= 1'b0;
                            out_valid     <= 1'b1;
                            state         <= RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                // A done left over from the previous operation may still be high here.
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        out_quotient  <= sq ? -div_quotient : div_quotient;
                        out_remainder <= sr ? -div_remainder : div_remainder;
                        out_dz        <= 1'b0;
                        out_ovf       <= ovf_pending;
                        out_valid     <= 1'b1;
                        div_start     <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_signed_ctrl.sv
// Bench for div_signed_ctrl at N = M = 8 with a cycle-timed behavioural
// divider standing in for div_module.
module tb_div_signed_ctrl;

    localparam int unsigned N = 8;
    localparam int unsigned M = 8;
    localparam int NORM_LAT = N + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [N-1:0] in_dividend;
    logic [M-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_quotient;
    logic [M-1:0] out_remainder;
    logic         out_dz;
    logic         out_ovf;
    logic         div_start;
    logic [N-1:0] div_dividend;
    logic [M-1:0] div_divisor;
    logic         div_done;
    logic [N-1:0] div_quotient;
    logic [M-1:0] div_remainder;

    int passed = 0;
    int total  = 0;
    int start_cycles = 0;

    always #5 clk = ~clk;

    div_signed_ctrl #(.N(N), .M(M)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dz(out_dz), .out_ovf(out_ovf),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // Divider stand-in: loads on start, N iteration cycles, done held until start drops.
    int dstate;
    int dcnt;
    logic [N-1:0] da;
    logic [M-1:0] db;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dstate <= 0; dcnt <= 0; da <= '0; db <= '0;
            div_done <= 1'b0; div_quotient <= '0; div_remainder <= '0;
        end else begin
            case (dstate)
                0: if (div_start) begin
                    da <= div_dividend; db <= div_divisor; dcnt <= N; dstate <= 1;
                end
                1: if (dcnt == 1) begin
                    div_quotient  <= (db == 0) ? '1 : da / N'(db);
                    div_remainder <= (db == 0) ? da[M-1:0] : M'(da % N'(db));
                    div_done <= 1'b1; dstate <= 2;
                end else dcnt <= dcnt - 1;
                default: if (!div_start) begin
                    div_done <= 1'b0; dstate <= 0;
                end
            endcase
        end
    end

    // Counts clock cycles in which the divider is being started.
    always_ff @(posedge clk) begin
        if (div_start) start_cycles <= start_cycles + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference arithmetic straight from the division rules.
    function automatic void ref_div(input logic s, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz, output logic ovf);
        int sa, sb;
        dz = 1'b0; ovf = 1'b0;
        if (b == 0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) begin
                q = 8'h80; r = 8'h00; ovf = 1'b1;
            end else begin
                q = 8'(sa / sb);
                r = 8'(sa % sb);
            end
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // One request/response; out_ready held low for 'hold' cycles once the result is visible.
    task automatic do_op(input string name, input logic s, input logic [7:0] a, input logic [7:0] b,
                         input int hold, output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ovf, output int lat, output int starts);
        int t;
        int s0;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            chk({name, " in_ready timeout"}, 64'(in_ready), 64'd1);
        end
        in_valid = 1'b1; in_signed = s; in_dividend = a; in_divisor = b;
        s0 = start_cycles;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) chk({name, " out_valid timeout"}, 64'(out_valid), 64'd1);
        q = out_quotient; r = out_remainder; dz = out_dz; ovf = out_ovf;
        starts = start_cycles - s0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, " held valid"}, 64'(out_valid), 64'd1);
            chk({name, " held data"}, {48'd0, out_quotient, out_remainder}, {48'd0, q, r});
            chk({name, " held in_ready"}, 64'(in_ready), 64'd0);
            chk({name, " held div_start"}, 64'(div_start), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " valid drop"}, 64'(out_valid), 64'd0);
    endtask

    typedef struct {
        string      name;
        logic       s;
        logic [7:0] a, b, q, r;
        logic       dz, ovf;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] q, r, eq, er, a, b;
        logic dz, ovf, edz, eovf, s;
        int lat, starts;

        vecs.push_back('{"u200/7",   1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, 1'b0, NORM_LAT});
        vecs.push_back('{"s-7/2",    1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0, 1'b0, NORM_LAT});
        vecs.push_back('{"s7/-2",    1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0, 1'b0, NORM_LAT});
        vecs.push_back('{"s-7/-2",   1'b1, 8'hF9,  8'hFE, 8'h03,  8'hFF, 1'b0, 1'b0, NORM_LAT});
        vecs.push_back('{"sMIN/-1",  1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, 1'b1, NORM_LAT});
        vecs.push_back('{"u80/FF",   1'b0, 8'h80,  8'hFF, 8'h00,  8'h80, 1'b0, 1'b0, NORM_LAT});
        vecs.push_back('{"u55/0",    1'b0, 8'h55,  8'h00, 8'hFF,  8'h55, 1'b1, 1'b0, 1});
        vecs.push_back('{"s55/0",    1'b1, 8'h55,  8'h00, 8'hFF,  8'h55, 1'b1, 1'b0, 1});

        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_dividend = '0; in_divisor = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset outs", {out_quotient, out_remainder, 6'd0, out_dz, out_ovf, 7'd0, div_start,
                           div_dividend, div_divisor}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready after release", 64'(in_ready), 64'd1);

        // Directed table.
        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, 0, q, r, dz, ovf, lat, starts);
            chk({vecs[i].name, " q"},   64'(q),   64'(vecs[i].q));
            chk({vecs[i].name, " r"},   64'(r),   64'(vecs[i].r));
            chk({vecs[i].name, " dz"},  64'(dz),  64'(vecs[i].dz));
            chk({vecs[i].name, " ovf"}, 64'(ovf), 64'(vecs[i].ovf));
            chk({vecs[i].name, " lat"}, 64'(lat), 64'(vecs[i].lat));
            if (vecs[i].dz) chk({vecs[i].name, " no start"}, 64'(starts), 64'd0);
        end

        // Backpressure then an immediate back-to-back request.
        do_op("bp", 1'b0, 8'd200, 8'd7, 5, q, r, dz, ovf, lat, starts);
        chk("bp q", 64'(q), 64'd28);
        chk("bp r", 64'(r), 64'd4);
        do_op("b2b", 1'b1, 8'hF9, 8'h02, 0, q, r, dz, ovf, lat, starts);
        chk("b2b q", 64'(q), 64'hFD);
        chk("b2b r", 64'(r), 64'hFF);
        chk("b2b lat", 64'(lat), 64'(NORM_LAT));

        // Reset while the divider is running.
        in_valid = 1'b1; in_signed = 1'b0; in_dividend = 8'd200; in_divisor = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid-op div_start", 64'(div_start), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst async outs", {out_quotient, out_remainder, 5'd0, out_valid, out_dz, out_ovf,
                               6'd0, in_ready, div_start, div_dividend, div_divisor}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("post-rst", 1'b0, 8'd100, 8'd10, 0, q, r, dz, ovf, lat, starts);
        chk("post-rst q", 64'(q), 64'd10);
        chk("post-rst r", 64'(r), 64'd0);
        chk("post-rst lat", 64'(lat), 64'(NORM_LAT));

        // Randomized requests against the reference arithmetic.
        for (int k = 0; k < 60; k++) begin
            s = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 9))
                0: b = 8'h00;
                1: begin a = 8'h80; b = 8'hFF; end
                2: b = 8'h01;
                default: ;
            endcase
            ref_div(s, a, b, eq, er, edz, eovf);
            do_op("rand", s, a, b, int'($urandom_range(0, 2)), q, r, dz, ovf, lat, starts);
            chk("rand q", 64'(q), 64'(eq));
            chk("rand r", 64'(r), 64'(er));
            chk("rand flags", {62'd0, dz, ovf}, {62'd0, edz, eovf});
            chk("rand lat", 64'(lat), (b == 0) ? 64'd1 : 64'(NORM_LAT));
            if (b == 0) chk("rand no start", 64'(starts), 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_signed_ctrl.md
Name: div_signed_ctrl

Overview:
Request/response front-end that sits directly upstream of the team's unsigned sequential divider (div_module) and consumes its results.
- Accepts signed or unsigned operand pairs on a valid/ready interface.
- Converts signed operands to magnitudes and drives the divider's level start/done protocol.
- Applies the sign fix-up: truncation toward zero; remainder takes the sign of the dividend.
- Short-circuits divide-by-zero without using the divider.
- Returns results on a valid/ready interface with status flags.

Parameters:
N, 64, dividend/quotient width; must match the divider's N.
M, 64, divisor/remainder width; must match the divider's M; M <= N.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready at posedge
in_signed  in  1  1 = two's-complement operands, 0 = unsigned
in_dividend  in  N  dividend
in_divisor  in  M  divisor
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  result consumer ready
out_quotient  out  N  quotient
out_remainder  out  M  remainder
out_dz  out  1  divisor was zero
out_ovf  out  1  signed overflow (MIN / -1)
div_start  out  1  divider start (level)
div_dividend  out  N  magnitude of dividend to divider
div_divisor  out  M  magnitude of divisor to divider
div_done  in  1  divider done
div_quotient  in  N  divider quotient
div_remainder  in  M  divider remainder

Behaviour:
- Reset: all outputs and internal registers are cleared to 0; state = IDLE. in_ready is 0 during reset and 1 in the first cycle after release. rst is shared with the divider. Reset mid-operation aborts the operation and drops the result.
- States: IDLE, ISSUE, WAIT, RESP. in_ready = (state == IDLE).
- IDLE, on accept:
  - Capture sq = in_signed & (dividend MSB ^ divisor MSB) and sr = in_signed & dividend MSB.
  - div_dividend <= in_signed & MSB ? -in_dividend : in_dividend. Apply the same rule for div_divisor. Negation is modulo 2^width, so |MIN| = 2^(N-1) as unsigned.
  - ovf <= in_signed & dividend == 1 followed by N-1 zeros & divisor == all-ones.
  - If in_divisor == 0, go to RESP with:
    - quotient = all-ones
    - remainder = in_dividend[M-1:0]
    - dz = 1, ovf = 0
    - the divider is not started.
  - Otherwise go to ISSUE.
- ISSUE: div_start = 1 for one cycle, then go to WAIT. div_done is ignored in ISSUE because it may hold a stale 1 from the previous operation.
- WAIT: div_start held at 1. On div_done = 1:
  - out_quotient <= sq ? -div_quotient : div_quotient
  - out_remainder <= sr ? -div_remainder : div_remainder
  - Go to RESP.
- RESP: div_start = 0 and out_valid = 1. On out_ready, out_valid drops next cycle and state returns to IDLE. Outputs stay stable while out_valid & !out_ready.
- div_start is low for at least 2 cycles between operations, so the divider returns to its IDLE.
- Latency from accept edge to out_valid high:
  - N+3 cycles normally (1 ISSUE, N iterations, 1 divider done cycle, 1 capture).
  - 1 cycle on divide-by-zero.
- Throughput: one operation in flight; no new accept until the response is consumed.
- MIN / -1 (signed) gives quotient = MIN (wraps), remainder = 0, ovf = 1.
- Unsigned requests never set ovf.
- out_dz and out_ovf are valid only with out_valid.

Test Plan:
(N = M = 8 for all scenarios.)
1. Unsigned 200/7 -> quotient 28, remainder 4, dz = 0, ovf = 0; out_valid rises exactly 11 cycles after the accept edge.
2. Signed -7/2 (0xF9/0x02) -> quotient 0xFD (-3), remainder 0xFF (-1). Signed 7/-2 -> quotient 0xFD, remainder 0x01. Signed -7/-2 -> quotient 0x03, remainder 0xFF.
3. Signed 0x80/0xFF -> quotient 0x80, remainder 0x00, ovf = 1. Unsigned 0x80/0xFF -> quotient 0, remainder 0x80, ovf = 0.
4. 0x55/0 (either mode) -> quotient 0xFF, remainder 0x55, dz = 1, 1 cycle after accept; div_start never asserts.
5. Backpressure:
   - out_ready held low for 5 cycles -> out_valid and data stable, in_ready = 0.
   - Then out_ready pulses -> IDLE; a back-to-back request completes correctly with no stale-done early capture.
6. rst asserted during WAIT -> all outputs 0 immediately. After release, 100/10 returns quotient 10, remainder 0.
